mdu_scheduler: RTL and testbench



---
 rtl/mdu_scheduler.sv | 178 +++++++++++++++++
 tb/tb_mdu_scheduler.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_scheduler.sv
// mdu_scheduler
//   Multiply/divide scheduler for the 5-stage MIPS pipeline. Owns the
//   architectural HI/LO registers, sequences multi-cycle mult/multu/div/divu
//   issued from E, and stalls D for any MD-class instruction while occupied.
//   The 64-bit result is computed when the operation is accepted and held in
//   a pending register; it reaches HI/LO only when the latency count expires.
//
// Ports
//   Clk      in   rising-edge clock
//   Reset    in   synchronous, active-high reset
//   E_Start  in   E-stage instruction is a qualified MDU op
//   E_MDOp   in   [2:0] 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo
//   E_RS     in   [31:0] dividend / multiplicand / mthi-mtlo source
//   E_RT     in   [31:0] divisor / multiplier
//   D_IsMD   in   D-stage instruction is an MD-class instruction
//   Busy     out  multi-cycle operation in progress
//   Stall    out  freeze PC and F/D, bubble into E
//   HI, LO   out  [31:0] architectural HI/LO
module mdu_scheduler #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        E_Start,
    input  logic [2:0]  E_MDOp,
    input  logic [31:0] E_RS,
    input  logic [31:0] E_RT,
    input  logic        D_IsMD,
    output logic        Busy,
    output logic        Stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned CW = $clog2(DIV_CYCLES + 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } md_op_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    hi_q, hi_d;
    logic [31:0]    lo_q, lo_d;
    logic [63:0]    pend_q, pend_d;
    logic           pend_wr_q, pend_wr_d;

    md_op_e         op;
    logic           start_md;

    // Arithmetic datapath
    logic [63:0]    rs_sx, rt_sx, prod_s, prod_u;
    logic           rs_neg, rt_neg;
    logic [31:0]    rs_abs, rt_abs, div_s, div_u;
    logic [31:0]    q_mag, r_mag, q_s, r_s, q_u, r_u;

    assign op       = md_op_e'(E_MDOp);
    assign start_md = E_Start & ((op == OP_MULT) | (op == OP_MULTU) |
                                 (op == OP_DIV)  | (op == OP_DIVU));

    // Signed product equals the low 64 bits of the sign-extended product.
    assign rs_sx  = {{32{E_RS[31]}}, E_RS};
    assign rt_sx  = {{32{E_RT[31]}}, E_RT};
    assign prod_s = rs_sx * rt_sx;
    assign prod_u = {32'd0, E_RS} * {32'd0, E_RT};

    // Signed divide on magnitudes, then restore signs: quotient negative when
    // operand signs differ, remainder takes the dividend's sign. The magnitude
    // of 0x80000000 is itself, which yields the required 0x80000000 quotient
    // for 0x80000000 / -1. Zero divisors are replaced by 1 to keep the
    // datapath defined; the result is never committed in that case.
    assign rs_neg = E_RS[31];
    assign rt_neg = E_RT[31];
    assign rs_abs = rs_neg ? (~E_RS + 32'd1) : E_RS;
    assign rt_abs = rt_neg ? (~E_RT + 32'd1) : E_RT;
    assign div_s  = (E_RT == 32'd0) ? 32'd1 : rt_abs;
    assign div_u  = (E_RT == 32'd0) ? 32'd1 : E_RT;
    assign q_mag  = rs_abs / div_s;
    assign r_mag  = rs_abs % div_s;
    assign q_s    = (rs_neg ^ rt_neg) ? (~q_mag + 32'd1) : q_mag;
    assign r_s    = rs_neg ? (~r_mag + 32'd1) : r_mag;
    assign q_u    = E_RS / div_u;
    assign r_u    = E_RS % div_u;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_d    = pend_q;
        pend_wr_d = pend_wr_q;

        case (state_q)
            IDLE: begin
                if (E_Start) begin
                    case (op)
                        OP_MULT: begin
                            pend_d    = prod_s;
                            pend_wr_d = 1'b1;
                            cnt_d     = CW'(MULT_CYCLES);
                            state_d   = BUSY;
                        end
                        OP_MULTU: begin
                            pend_d    = prod_u;
                            pend_wr_d = 1'b1;
                            cnt_d     = CW'(MULT_CYCLES);
                            state_d   = BUSY;
                        end
                        OP_DIV: begin
                            pend_d    = {r_s, q_s};
                            pend_wr_d = (E_RT != 32'd0);
                            cnt_d     = CW'(DIV_CYCLES);
                            state_d   = BUSY;
                        end
                        OP_DIVU: begin
                            pend_d    = {r_u, q_u};
                            pend_wr_d = (E_RT != 32'd0);
                            cnt_d     = CW'(DIV_CYCLES);
                            state_d   = BUSY;
                        end
                        OP_MTHI: hi_d = E_RS;
                        OP_MTLO: lo_d = E_RS;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                // E_Start is deliberately ignored here.
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    if (pend_wr_q) begin
                        hi_d = pend_q[63:32];
                        lo_d = pend_q[31:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_q    <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_q    <= pend_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign Busy  = (state_q == BUSY);
    assign Stall = D_IsMD & (Busy | start_md);
    assign HI    = hi_q;
    assign LO    = lo_q;

endmodule

// File: tb/tb_mdu_scheduler.sv
module tb_mdu_scheduler;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        E_Start;
    logic [2:0]  E_MDOp;
    logic [31:0] E_RS;
    logic [31:0] E_RT;
    logic        D_IsMD;
    logic        Busy;
    logic        Stall;
    logic [31:0] HI;
    logic [31:0] LO;

    always #5 Clk = ~Clk;

    mdu_scheduler #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .E_Start (E_Start),
        .E_MDOp  (E_MDOp),
        .E_RS    (E_RS),
        .E_RT    (E_RT),
        .D_IsMD  (D_IsMD),
        .Busy    (Busy),
        .Stall   (Stall),
        .HI      (HI),
        .LO      (LO)
    );

    int unsigned checks = 0;
    int unsigned fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: one entry per accepted multi-cycle operation.
    typedef struct {
        int unsigned cyc;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;
    exp_t sb[$];

    // Behavioural reference model: remaining busy cycles plus architectural HI/LO.
    int unsigned m_left    = 0;
    int unsigned abort_cnt = 0;
    logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
    logic        m_wr = 1'b0;

    always @(posedge Clk) begin
        logic [63:0] res;
        logic        wr;
        int unsigned n;
        longint      p, q, r;
        res = '0; wr = 1'b0; n = 0;
        if (Reset) begin
            if (m_left != 0) abort_cnt <= abort_cnt + 1;
            m_left <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
        end else if (m_left != 0) begin
            if (E_Start) $display("NOTE: E_Start seen while unit busy (op %0d), ignored", E_MDOp);
            if (m_left == 1 && m_wr) begin
                m_hi <= m_phi;
                m_lo <= m_plo;
            end
            m_left <= m_left - 1;
        end else if (E_Start) begin
            case (E_MDOp)
                3'd1: begin
                    p = longint'($signed(E_RS)) * longint'($signed(E_RT));
                    res = p; wr = 1'b1; n = MC;
                end
                3'd2: begin
                    res = {32'd0, E_RS} * {32'd0, E_RT}; wr = 1'b1; n = MC;
                end
                3'd3: begin
                    n = DC;
                    if (E_RT != 0) begin
                        q = longint'($signed(E_RS)) / longint'($signed(E_RT));
                        r = longint'($signed(E_RS)) % longint'($signed(E_RT));
                        res = {r[31:0], q[31:0]}; wr = 1'b1;
                    end
                end
                3'd4: begin
                    n = DC;
                    if (E_RT != 0) begin
                        res = {E_RS % E_RT, E_RS / E_RT}; wr = 1'b1;
                    end
                end
                3'd5: m_hi <= E_RS;
                3'd6: m_lo <= E_RS;
                default: ;
            endcase
            if (n != 0) begin
                m_left <= n;
                m_phi  <= res[63:32];
                m_plo  <= res[31:0];
                m_wr   <= wr;
                sb.push_back('{cyc: n, hi: (wr ? res[63:32] : m_hi), lo: (wr ? res[31:0] : m_lo)});
            end
        end
    end

    // Monitor: per-cycle Busy/Stall/HI/LO against the model, plus scoreboard
    // pop whenever the DUT drops Busy.
    logic        mon_en    = 1'b0;
    logic        busy_prev = 1'b0;
    int unsigned bcnt      = 0;
    int unsigned abort_seen = 0;

    always @(negedge Clk) begin
        logic exp_stall;
        exp_t e;
        if (mon_en) begin
            exp_stall = D_IsMD && ((m_left != 0) ||
                        (E_Start && E_MDOp >= 3'd1 && E_MDOp <= 3'd4));
            chk("busy",  {31'd0, Busy},  {31'd0, (m_left != 0)});
            chk("stall", {31'd0, Stall}, {31'd0, exp_stall});
            chk("hi", HI, m_hi);
            chk("lo", LO, m_lo);
            if (Busy) bcnt++;
            if (busy_prev && !Busy) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    if (abort_seen != abort_cnt) begin
                        abort_seen++;
                    end else begin
                        chk("sb_busy_len", bcnt, e.cyc);
                        chk("sb_hi", HI, e.hi);
                        chk("sb_lo", LO, e.lo);
                    end
                end
                bcnt = 0;
            end
            busy_prev = Busy;
        end
    end

    // Stimulus
    int ismd_mode = 0;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_ismd();
        D_IsMD = (ismd_mode != 0) ? 1'b1 : 1'($urandom_range(0, 1));
    endtask

    task automatic idle_inputs();
        E_Start = 1'b0;
        E_MDOp  = 3'($urandom_range(0, 7));
        E_RS    = $urandom;
        E_RT    = $urandom;
        set_ismd();
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int inj);
        int k;
        E_Start = 1'b1; E_MDOp = op; E_RS = a; E_RT = b; set_ismd();
        step();
        k = 0;
        while (m_left != 0 && k < 40) begin
            if (k == inj) begin
                E_Start = 1'b1;
                E_MDOp  = 3'($urandom_range(1, 6));
                E_RS    = $urandom;
                E_RT    = $urandom;
                set_ismd();
            end else begin
                idle_inputs();
            end
            step();
            k++;
        end
        idle_inputs();
        chk("op_timeout", {31'd0, (m_left != 0)}, 32'd0);
    endtask

    initial begin
        logic [31:0] a, b;
        logic [2:0]  op;
        Reset = 1'b1;
        idle_inputs();
        step();
        mon_en = 1'b1;
        step();
        Reset = 1'b0;
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        chk("rst_busy", {31'd0, Busy}, 32'd0);

        issue(3'd1, 32'hFFFF_FFFE, 32'd3, -1);
        chk("mult_hi", HI, 32'hFFFF_FFFF);
        chk("mult_lo", LO, 32'hFFFF_FFFA);

        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        chk("multu_hi", HI, 32'hFFFF_FFFE);
        chk("multu_lo", LO, 32'h0000_0001);

        issue(3'd3, 32'hFFFF_FFF9, 32'd2, -1);
        chk("div_hi", HI, 32'hFFFF_FFFF);
        chk("div_lo", LO, 32'hFFFF_FFFD);

        issue(3'd4, 32'd7, 32'd0, -1);
        chk("divu0_hi", HI, 32'hFFFF_FFFF);
        chk("divu0_lo", LO, 32'hFFFF_FFFD);

        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        chk("divovf_hi", HI, 32'h0000_0000);
        chk("divovf_lo", LO, 32'h8000_0000);

        issue(3'd5, 32'h1234_5678, 32'd0, -1);
        chk("mthi_hi", HI, 32'h1234_5678);
        issue(3'd6, 32'h9ABC_DEF0, 32'd0, -1);
        chk("mtlo_lo", LO, 32'h9ABC_DEF0);
        chk("mtlo_hi", HI, 32'h1234_5678);

        // Reset during the fourth busy cycle of a divide.
        E_Start = 1'b1; E_MDOp = 3'd3; E_RS = 32'd100; E_RT = 32'd7; set_ismd();
        step();
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            step();
        end
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("abort_busy", {31'd0, Busy}, 32'd0);
        chk("abort_hi", HI, 32'd0);
        chk("abort_lo", LO, 32'd0);
        for (int i = 0; i < 12; i++) step();
        chk("abort_nocommit_lo", LO, 32'd0);

        issue(3'd1, 32'd3, 32'd4, -1);
        chk("post_abort_lo", LO, 32'd12);

        // D_IsMD held high across a multiply with an E_Start injected mid-busy.
        ismd_mode = 1;
        issue(3'd1, 32'd6, 32'd7, 2);
        ismd_mode = 0;
        chk("inject_lo", LO, 32'd42);
        chk("inject_hi", HI, 32'd0);

        for (int t = 0; t < 40; t++) begin
            op = 3'($urandom_range(1, 6));
            case ($urandom_range(0, 3))
                0: a = 32'h8000_0000;
                1: a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = $urandom_range(1, 9);
                default: b = $urandom;
            endcase
            issue(op, a, b, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1);
        end

        for (int i = 0; i < 3; i++) step();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
